axis_to_axi_wr: RTL and testbench

Stream-to-memory write master that feeds the team's AXI4 RAM slave. It accepts a command (start address, word count) and consumes that many AXI-Stream words. It emits them as AXI4 INCR write bursts, split at MAX_BURST_LEN and at 4 KB boundaries, with one burst outstanding at a time. It reports completion and any non-OKAY write response.

---
 rtl/axis_to_axi_wr.sv | 187 ++++++++++++++++++
 tb/tb_axis_to_axi_wr.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_to_axi_wr.sv
// rtl/axis_to_axi_wr.sv - AXI-Stream to AXI4 INCR burst write master
// Splits each command at MAX_BURST_LEN and 4 KB boundaries and keeps one burst in flight.
module axis_to_axi_wr #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 16,
   parameter int STRB_WIDTH    = DATA_WIDTH / 8,
   parameter int ID_WIDTH      = 8,
   parameter int AXI_ID        = 0,
   parameter int MAX_BURST_LEN = 16,
   parameter int LEN_WIDTH     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int SIZE = $clog2(STRB_WIDTH);
   localparam int CW   = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic [8:0]            beats_q, beats_d;
   logic [7:0]            awlen_q, awlen_d;
   logic [7:0]            beat_cnt_q, beat_cnt_d;
   logic                  error_q, error_d;
   logic                  done_q, done_d;

   logic [ADDR_WIDTH-1:0] cmd_addr_aligned;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic [LEN_WIDTH-1:0]  remaining_next;
   logic                  w_hs;
   logic                  unused_bid;

   // Beats for the next burst: limited by words left, MAX_BURST_LEN and distance to the 4 KB page end.
   function automatic logic [CW-1:0] calc_beats(input logic [ADDR_WIDTH-1:0] a,
                                                input logic [LEN_WIDTH-1:0]  r);
      logic [CW-1:0] to_boundary;
      logic [CW-1:0] n;
      to_boundary = CW'((13'd4096 - {1'b0, a[11:0]}) >> SIZE);
      n = CW'(MAX_BURST_LEN);
      if (CW'(r) < n) n = CW'(r);
      if (to_boundary < n) n = to_boundary;
      return n;
   endfunction

   assign cmd_addr_aligned = cmd_addr & ALIGN_MASK;
   assign addr_next        = addr_q + (ADDR_WIDTH'(beats_q) << SIZE);
   assign remaining_next   = remaining_q - LEN_WIDTH'(beats_q);
   assign w_hs             = m_axi_wvalid && m_axi_wready;
   assign unused_bid       = ^m_axi_bid;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      beats_d     = beats_q;
      awlen_d     = awlen_q;
      beat_cnt_d  = beat_cnt_q;
      error_d     = error_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d      = cmd_addr_aligned;
               remaining_d = cmd_len;
               error_d     = 1'b0;
               if (cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  beats_d = 9'(calc_beats(cmd_addr_aligned, cmd_len));
                  awlen_d = 8'(beats_d - 9'd1);
                  state_d = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            if (m_axi_awready) begin
               beat_cnt_d = 8'd0;
               state_d    = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_hs) begin
               if (beat_cnt_q == awlen_q) state_d = ST_RESP;
               else beat_cnt_d = beat_cnt_q + 8'd1;
            end
         end
         ST_RESP: begin
            if (m_axi_bvalid) begin
               error_d     = error_q | (m_axi_bresp != 2'b00);
               addr_d      = addr_next;
               remaining_d = remaining_next;
               if (remaining_next != '0) begin
                  beats_d = 9'(calc_beats(addr_next, remaining_next));
                  awlen_d = 8'(beats_d - 9'd1);
                  state_d = ST_ADDR;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         beats_q     <= '0;
         awlen_q     <= '0;
         beat_cnt_q  <= '0;
         error_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         beats_q     <= beats_d;
         awlen_q     <= awlen_d;
         beat_cnt_q  <= beat_cnt_d;
         error_q     <= error_d;
         done_q      <= done_d;
      end
   end

   // Stream and W channel are joined combinationally so no word is taken outside DATA.
   assign cmd_ready     = (state_q == ST_IDLE) && !rst;
   assign s_axis_tready = (state_q == ST_DATA) && m_axi_wready;
   assign m_axi_wvalid  = (state_q == ST_DATA) && s_axis_tvalid;
   assign m_axi_wdata   = s_axis_tdata;
   assign m_axi_wstrb   = '1;
   assign m_axi_wlast   = (state_q == ST_DATA) && (beat_cnt_q == awlen_q);

   assign m_axi_awid    = ID_WIDTH'(AXI_ID);
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = awlen_q;
   assign m_axi_awsize  = 3'(SIZE);
   assign m_axi_awburst = 2'b01;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = (state_q == ST_ADDR);
   assign m_axi_bready  = (state_q == ST_RESP);

   assign busy  = (state_q != ST_IDLE);
   assign done  = done_q;
   assign error = error_q;

endmodule

// File: tb/tb_axis_to_axi_wr.sv
// tb/tb_axis_to_axi_wr.sv - self-checking bench for axis_to_axi_wr
// Randomized AXI RAM slave and stream source checked against a burst-splitting reference model.
module tb_axis_to_axi_wr;
   localparam int DW = 32, AW = 16, IDW = 8, LW = 16, MAXB = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [AW-1:0]  cmd_addr;
   logic [LW-1:0]  cmd_len;
   logic           cmd_valid, cmd_ready;
   logic [DW-1:0]  s_axis_tdata;
   logic           s_axis_tvalid, s_axis_tready;
   logic [IDW-1:0] m_axi_awid;
   logic [AW-1:0]  m_axi_awaddr;
   logic [7:0]     m_axi_awlen;
   logic [2:0]     m_axi_awsize;
   logic [1:0]     m_axi_awburst;
   logic           m_axi_awlock;
   logic [3:0]     m_axi_awcache;
   logic [2:0]     m_axi_awprot;
   logic           m_axi_awvalid, m_axi_awready;
   logic [DW-1:0]  m_axi_wdata;
   logic [3:0]     m_axi_wstrb;
   logic           m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic [IDW-1:0] m_axi_bid;
   logic [1:0]     m_axi_bresp;
   logic           m_axi_bvalid, m_axi_bready;
   logic           busy, done, error;

   always #5 clk = ~clk;

   axis_to_axi_wr #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(4), .ID_WIDTH(IDW),
      .AXI_ID(0), .MAX_BURST_LEN(MAXB), .LEN_WIDTH(LW)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .busy(busy), .done(done), .error(error)
   );

   typedef struct { logic [15:0] addr; int len; } aw_rec_t;
   typedef struct { logic [15:0] addr; int len; int err_burst; bit bp; int exp_bursts; bit exp_err; int exp_lat; } vec_t;

   aw_rec_t     exp_aw[$];
   aw_rec_t     e;
   logic [31:0] src_q[$];
   logic [31:0] mem [0:16383];
   vec_t        vecs [8];

   int   checks = 0, errors = 0;
   int   cyc = 0;
   bit   bp_mode = 0;
   int   err_burst = -1;
   int   src_idx = 0, done_cnt = 0, aw_hs = 0, aw_valid_cycles = 0, tready_cycles = 0, burst_no = 0;
   int   accept_cyc = -1, done_cyc = -1, beat = 0, cur_len = 0, model_bursts = 0;
   bit   b_pend = 0, b_fire = 0, t_hold = 0, aw_stall = 0, model_err = 0;
   logic err_at_done = 1'b0;
   logic [15:0] stall_addr = '0, cur_addr = '0;
   logic [7:0]  stall_len = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Slave + source drive at negedge, then sample what will handshake at the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
         s_axis_tvalid = 1'b0; s_axis_tdata = '0;
         b_pend = 0; b_fire = 0; t_hold = 0; aw_stall = 0;
      end else begin
         m_axi_awready = bp_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
         m_axi_wready  = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (src_idx < src_q.size()) begin
            s_axis_tdata = src_q[src_idx];
            if (!t_hold) s_axis_tvalid = bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
         end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = '0;
         end
         if (b_fire) begin
            m_axi_bvalid = 1'b0;
            b_fire = 0;
         end
         if (b_pend && !m_axi_bvalid && (!bp_mode || $urandom_range(0, 2) == 0)) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = (burst_no == err_burst) ? 2'b10 : 2'b00;
         end
      end
      #1;
      if (!rst) begin
         if (cmd_valid && cmd_ready) accept_cyc = cyc;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            err_at_done = error;
         end
         if (aw_stall)
            chk("aw_stable", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, {1'b1, stall_addr, stall_len});
         aw_stall   = m_axi_awvalid && !m_axi_awready;
         stall_addr = m_axi_awaddr;
         stall_len  = m_axi_awlen;
         if (m_axi_awvalid) aw_valid_cycles++;
         if (s_axis_tready) tready_cycles++;
         if (m_axi_awvalid && m_axi_awready) begin
            aw_hs++;
            chk("aw_const", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot},
                {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
            chk("aw_expected", exp_aw.size() != 0, 1);
            if (exp_aw.size() != 0) begin
               e = exp_aw.pop_front();
               chk("awaddr", m_axi_awaddr, e.addr);
               chk("awlen", m_axi_awlen, e.len);
            end
            cur_addr = m_axi_awaddr;
            cur_len  = m_axi_awlen;
            beat     = 0;
         end
         if ((m_axi_wvalid && m_axi_wready) || (s_axis_tvalid && s_axis_tready))
            chk("w_vs_stream", {m_axi_wvalid && m_axi_wready, m_axi_wdata},
                {s_axis_tvalid && s_axis_tready, s_axis_tdata});
         if (m_axi_wvalid && m_axi_wready) begin
            chk("wstrb", m_axi_wstrb, 4'hf);
            chk("wlast", m_axi_wlast, beat == cur_len);
            mem[cur_addr[15:2] + 14'(beat)] = m_axi_wdata;
            beat++;
            if (m_axi_wlast) b_pend = 1;
         end
         if (s_axis_tvalid && s_axis_tready) src_idx++;
         t_hold = s_axis_tvalid && !s_axis_tready;
         if (m_axi_bvalid && m_axi_bready) begin
            b_pend = 0;
            b_fire = 1;
            burst_no++;
         end
      end
   end

   // Reference model: walk the command with plain arithmetic and list the bursts it must produce.
   task automatic start_cmd(input logic [15:0] addr, input int len, input int eb, input bit bp, input int extra);
      int a, r, n, room;
      aw_rec_t rec;
      exp_aw.delete();
      src_q.delete();
      src_idx = 0; done_cnt = 0; aw_hs = 0; aw_valid_cycles = 0; tready_cycles = 0; burst_no = 0;
      accept_cyc = -1; done_cyc = -1; beat = 0; err_burst = eb; bp_mode = bp;
      a = int'(addr) / 4 * 4;
      r = len;
      while (r > 0) begin
         room = (4096 - (a % 4096)) / 4;
         n = r;
         if (n > MAXB) n = MAXB;
         if (n > room) n = room;
         rec.addr = 16'(a);
         rec.len  = n - 1;
         exp_aw.push_back(rec);
         a = (a + 4 * n) % 65536;
         r -= n;
      end
      model_bursts = exp_aw.size();
      model_err = (eb >= 0) && (eb < model_bursts);
      for (int i = 0; i < len + extra; i++) src_q.push_back($urandom);
      @(negedge clk);
      cmd_addr = addr; cmd_len = 16'(len); cmd_valid = 1'b1;
      #2 chk("cmd_ready_idle", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      #2;
      if (len > 0) chk("first_aw", {busy, m_axi_awvalid}, 2'b11);
      else chk("len0_done_next", {busy, done}, 2'b01);
   endtask

   task automatic finish_cmd(input logic [15:0] addr, input int len);
      int t;
      t = 0;
      while (done_cnt == 0 && t < 4000) begin
         @(negedge clk);
         #2;
         t++;
      end
      chk("done_seen", done_cnt != 0, 1);
      repeat (3) @(negedge clk);
      #2;
      chk("done_once", done_cnt, 1);
      chk("error_hold", error, model_err);
      chk("aw_all_issued", exp_aw.size(), 0);
      chk("words_taken", src_idx, len);
      for (int i = 0; i < len; i++) chk("ram", mem[14'((addr >> 2) + i)], src_q[i]);
   endtask

   initial begin
      int t;
      logic [15:0] ra;
      int rl, reb, rx;
      bit rbp;
      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_axi_bid = '0;
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      s_axis_tvalid = 1'b0; s_axis_tdata = '0;
      for (int i = 0; i < 16384; i++) mem[i] = '0;

      vecs[0] = '{16'h0000, 40, -1, 1'b0, 3, 1'b0, 47};
      vecs[1] = '{16'h0FF0,  8, -1, 1'b0, 2, 1'b0, 13};
      vecs[2] = '{16'h0123, 37, -1, 1'b1, 3, 1'b0, -1};
      vecs[3] = '{16'h2000, 40,  1, 1'b0, 3, 1'b1, 47};
      vecs[4] = '{16'h2000, 40, -1, 1'b1, 3, 1'b0, -1};
      vecs[5] = '{16'h0100,  0, -1, 1'b0, 0, 1'b0,  1};
      vecs[6] = '{16'hFFF8,  6, -1, 1'b0, 2, 1'b0, 11};
      vecs[7] = '{16'h0FC0, 16, -1, 1'b0, 1, 1'b0, 19};

      repeat (3) @(negedge clk);
      #2;
      chk("rst_ctrl", {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, s_axis_tready, m_axi_bready, busy, done, error}, 0);
      chk("rst_awaddr", m_axi_awaddr, 0);
      chk("rst_awlen", m_axi_awlen, 0);
      @(negedge clk);
      rst = 1'b0;
      #2 chk("post_rst_idle", {cmd_ready, busy}, 2'b10);

      for (int v = 0; v < 8; v++) begin
         start_cmd(vecs[v].addr, vecs[v].len, vecs[v].err_burst, vecs[v].bp, 3);
         finish_cmd(vecs[v].addr, vecs[v].len);
         chk("tbl_bursts", aw_hs, vecs[v].exp_bursts);
         chk("tbl_err", err_at_done, vecs[v].exp_err);
         if (vecs[v].exp_lat >= 0) chk("tbl_latency", done_cyc - accept_cyc, vecs[v].exp_lat);
         if (vecs[v].len == 0) chk("len0_quiet", {aw_valid_cycles, tready_cycles}, 0);
      end

      // Async reset in the middle of a burst, then a clean short command.
      start_cmd(16'h0400, 16, -1, 1'b0, 0);
      t = 0;
      while (beat != 5 && t < 100) begin
         @(negedge clk);
         #2;
         t++;
      end
      chk("reached_beat5", beat, 5);
      rst = 1'b1;
      #1 chk("rst_mid_data", {m_axi_awvalid, m_axi_wvalid, s_axis_tready, m_axi_bready, busy, cmd_ready, done}, 0);
      exp_aw.delete();
      src_q.delete();
      src_idx = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #2 chk("rst_release", {cmd_ready, busy}, 2'b10);
      start_cmd(16'h0800, 4, -1, 1'b0, 2);
      finish_cmd(16'h0800, 4);
      chk("after_rst_bursts", aw_hs, 1);
      chk("after_rst_latency", done_cyc - accept_cyc, 7);
      chk("after_rst_err", err_at_done, 0);

      for (int k = 0; k < 12; k++) begin
         ra  = 16'($urandom_range(0, 65535));
         rl  = $urandom_range(0, 60);
         reb = int'($urandom_range(0, 4)) - 1;
         rbp = 1'($urandom_range(0, 1));
         rx  = $urandom_range(0, 3);
         start_cmd(ra, rl, reb, rbp, rx);
         finish_cmd(ra, rl);
         chk("rnd_bursts", aw_hs, model_bursts);
         chk("rnd_err", err_at_done, model_err);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
